// File: rtl/alu_iter_exec.sv
// alu_iter_exec -- multi-cycle EX-stage execution unit.
//
// It takes the decoded ALU control bundle and the register or immediate
// operands, and produces a registered result with overflow and zero flags.
// Logical, arithmetic and compare ops complete in one cycle. Shifts iterate
// one bit per cycle. When the optional barrel shifter is built in, shifts
// also complete in one cycle. A valid/ready handshake on each side lets the
// core stall while a shift is iterating.
//
// Optional feature macro: ALU_BARREL_SHIFT_EN
//   defined   -> a combinational barrel shifter; no SHIFT state and no counter
//   undefined -> an iterative shifter that moves one bit per cycle
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   in_valid, in_ready  request handshake (in_ready is high only in IDLE)
//   ALU_control         op select: 0 zero, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 LUI,
//                       6 shift, 7 add, 8 sub, 9 slt; 10-15 act as op 0
//   shift_src           1: shift amount comes from a[4:0]; 0: from shamt
//   shift_dir           1: shift right; 0: shift left
//   shift_ari           1: arithmetic right shift
//   do_unsigned         unsigned compare; also suppresses overflow
//   a, b, shamt         operands and the instruction shift amount
//   out_valid, out_ready result handshake
//   result, overflow, zero  registered outputs
//   busy                unit is occupied
module alu_iter_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_control,
    input  logic             shift_src,
    input  logic             shift_dir,
    input  logic             shift_ari,
    input  logic             do_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic [4:0]       amt;

    // Signed overflow occurs when both operands of the effective addition
    // have the same sign and the sum's sign differs from it.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

`ifdef ALU_BARREL_SHIFT_EN
    function automatic logic [WIDTH-1:0] barrel_shift(input logic [WIDTH-1:0] v,
                                                      input logic [4:0]       k,
                                                      input logic             right,
                                                      input logic             arith);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        if (!right)
            return v << k;
        else if (arith)
            return $unsigned(sv >>> k);
        else
            return v >> k;
    endfunction
`else
    logic [WIDTH-1:0] shreg;
    logic [4:0]       cnt;
    logic             sh_dir;
    logic             sh_ari;
    logic [WIDTH-1:0] shreg_next;

    // A right shift fills from the top with the current MSB when the shift
    // is arithmetic, and with 0 otherwise. A left shift ignores sh_ari.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                    input logic             right,
                                                    input logic             arith);
        if (!right)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {arith & v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    assign shreg_next = shift_step(shreg, sh_dir, sh_ari);
`endif

    assign amt       = shift_src ? a[4:0] : shamt;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
`ifdef ALU_BARREL_SHIFT_EN
    assign busy      = (state == DONE);
`else
    assign busy      = (state != IDLE);
`endif

    // Single-cycle result for every op. In the iterative build, op 6 only
    // reaches this path when the shift amount is 0, so the result is just b.
    always_comb begin
        logic signed [WIDTH-1:0] sa, sb, sum, diff;
        res_c = '0;
        ovf_c = 1'b0;
        sa    = $signed(a);
        sb    = $signed(b);
        sum   = sa + sb;
        diff  = sa - sb;
        case (ALU_control)
            4'd1: res_c = a & b;
            4'd2: res_c = a | b;
            4'd3: res_c = a ^ b;
            4'd4: res_c = ~(a | b);
            4'd5: res_c = b << 16;
`ifdef ALU_BARREL_SHIFT_EN
            4'd6: res_c = barrel_shift(b, amt, shift_dir, shift_ari);
`else
            4'd6: res_c = b;
`endif
            4'd7: begin
                res_c = $unsigned(sum);
                ovf_c = !do_unsigned && add_ovf(sa, sb, sum);
            end
            4'd8: begin
                res_c = $unsigned(diff);
                ovf_c = !do_unsigned && sub_ovf(sa, sb, diff);
            end
            4'd9: res_c = {{(WIDTH-1){1'b0}}, (do_unsigned ? (a < b) : (sa < sb))};
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            shreg    <= '0;
            cnt      <= '0;
            sh_dir   <= 1'b0;
            sh_ari   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (ALU_control == 4'd6 && amt != 5'd0) begin
                            shreg  <= b;
                            cnt    <= amt;
                            sh_dir <= shift_dir;
                            sh_ari <= shift_ari;
                            state  <= SHIFT;
                        end else
`endif
                        begin
                            result   <= res_c;
                            overflow <= ovf_c;
                            zero     <= (res_c == '0);
                            state    <= DONE;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    shreg <= shreg_next;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result   <= shreg_next;
                        overflow <= 1'b0;
                        zero     <= (shreg_next == '0);
                        state    <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter_exec.sv
module tb_alu_iter_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_control;
    logic        shift_src, shift_dir, shift_ari, do_unsigned;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow, zero, busy;

    int errors = 0;
    int checks = 0;

    alu_iter_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_control(ALU_control), .shift_src(shift_src), .shift_dir(shift_dir),
        .shift_ari(shift_ari), .do_unsigned(do_unsigned), .a(a), .b(b),
        .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model built from the op table with plain wide arithmetic.
    function automatic void model(input logic [3:0] c, input logic src, input logic dir,
                                  input logic ari, input logic uns,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  input logic [4:0] sh,
                                  output logic [31:0] r, output logic ov, output int lat);
        int     k;
        longint s;
        k   = src ? int'(av[4:0]) : int'(sh);
        r   = 32'd0;
        ov  = 1'b0;
        lat = 1;
        case (c)
            4'd1: r = av & bv;
            4'd2: r = av | bv;
            4'd3: r = av ^ bv;
            4'd4: r = ~(av | bv);
            4'd5: r = {bv[15:0], 16'h0000};
            4'd6: begin
                if (!dir)     r = bv << k;
                else if (ari) r = 32'(longint'($signed(bv)) / (longint'(1) << k)
                                      - ((bv[31] && (bv & ((32'd1 << k) - 1)) != 0) ? 1 : 0));
                else          r = bv >> k;
`ifndef ALU_BARREL_SHIFT_EN
                lat = 1 + k;
`endif
            end
            4'd7: begin
                s  = longint'($signed(av)) + longint'($signed(bv));
                r  = av + bv;
                ov = !uns && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            4'd8: begin
                s  = longint'($signed(av)) - longint'($signed(bv));
                r  = av - bv;
                ov = !uns && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            4'd9: r = uns ? {31'd0, av < bv} : {31'd0, $signed(av) < $signed(bv)};
            default: r = 32'd0;
        endcase
    endfunction

    // Drives one request, then waits (bounded) for out_valid. It does not retire the result.
    task automatic do_op(input logic [3:0] c, input logic src, input logic dir, input logic ari,
                         input logic uns, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, output int lat, output logic busy_all);
        ALU_control = c; shift_src = src; shift_dir = dir; shift_ari = ari;
        do_unsigned = uns; a = av; b = bv; shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_all = busy;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            busy_all &= busy;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; ALU_control = 4'd7;
        shift_src = 0; shift_dir = 0; shift_ari = 0; do_unsigned = 0;
        a = 32'd3; b = 32'd4; shamt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if (overflow !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b zero=%b want 0 0", overflow, zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_add_overflow();
        int lat; logic ba;
        do_op(4'd7, 0, 0, 0, 0, 32'h7FFFFFFF, 32'd1, 5'd0, lat, ba);
        checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h want 80000000", result); end
        checks++; if (overflow !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL add_flags: got ovf=%b zero=%b want 1 0", overflow, zero); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
        retire();
        do_op(4'd7, 0, 0, 0, 1, 32'h7FFFFFFF, 32'd1, 5'd0, lat, ba);
        checks++; if (result !== 32'h80000000 || overflow !== 1'b0) begin errors++; $display("FAIL addu: got %h ovf=%b want 80000000 ovf=0", result, overflow); end
        retire();
    endtask

    task automatic test_compare();
        int lat; logic ba;
        do_op(4'd9, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 5'd0, lat, ba);
        checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt_signed: got %h want 1", result); end
        retire();
        do_op(4'd9, 0, 0, 0, 1, 32'hFFFFFFFF, 32'd1, 5'd0, lat, ba);
        checks++; if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL slt_unsigned: got %h zero=%b want 0 zero=1", result, zero); end
        retire();
    endtask

    task automatic test_var_shift();
        int lat; logic ba; int exp_lat;
`ifdef ALU_BARREL_SHIFT_EN
        exp_lat = 1;
`else
        exp_lat = 5;
`endif
        do_op(4'd6, 1, 1, 1, 0, 32'd4, 32'h80000000, 5'd17, lat, ba);
        checks++; if (result !== 32'hF8000000) begin errors++; $display("FAIL sra_result: got %h want f8000000", result); end
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sra_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL sra_busy: got %b want 1", ba); end
        retire();
    endtask

    task automatic test_zero_shift_lui();
        int lat; logic ba;
        do_op(4'd6, 0, 0, 0, 0, 32'd9, 32'h00001234, 5'd0, lat, ba);
        checks++; if (result !== 32'h00001234 || lat !== 1) begin errors++; $display("FAIL zero_shift: got %h lat=%0d want 00001234 lat=1", result, lat); end
        retire();
        do_op(4'd5, 0, 0, 0, 0, 32'd0, 32'h00001234, 5'd0, lat, ba);
        checks++; if (result !== 32'h12340000) begin errors++; $display("FAIL lui: got %h want 12340000", result); end
        retire();
    endtask

    task automatic test_backpressure();
        int lat; logic ba;
        do_op(4'd8, 0, 0, 0, 0, 32'd5, 32'd5, 5'd0, lat, ba);
        checks++; if (result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL sub_zero: got %h zero=%b want 0 zero=1", result, zero); end
        for (int i = 0; i < 3; i++) begin
            in_valid = (i % 2 == 0); ALU_control = 4'd2; a = $urandom | 32'd1; b = $urandom;
            @(posedge clk); #1;
            checks++;
            if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL backpressure_hold: got res=%h zero=%b ov=%b ir=%b want 0 1 1 0", result, zero, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        retire();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL backpressure_release: got ir=%b ov=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        int lat; logic ba;
        do_op(4'd2, 0, 0, 0, 0, 32'h0000F000, 32'h00000F00, 5'd0, lat, ba);
        retire();
        ALU_control = 4'd6; shift_src = 0; shift_dir = 0; shift_ari = 0;
        b = 32'h00000ABC; shamt = 5'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
`ifndef ALU_BARREL_SHIFT_EN
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_shift_state: got busy=%b ov=%b want 1 0", busy, out_valid); end
`endif
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_shift: got ov=%b res=%h busy=%b ir=%b want 0 0 0 1", out_valid, result, busy, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(4'd7, 0, 0, 0, 0, 32'd3, 32'd4, 5'd0, lat, ba);
        checks++; if (result !== 32'd7 || lat !== 1) begin errors++; $display("FAIL after_reset_op: got %h lat=%0d want 7 lat=1", result, lat); end
        retire();
    endtask

    task automatic test_random();
        int lat, exp_lat; logic ba;
        logic [3:0] c; logic src, dir, ari, uns; logic [31:0] av, bv, er; logic [4:0] sh; logic eo;
        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom_range(0, 15));
            if (i % 3 == 0) c = 4'd6;
            src = 1'($urandom); dir = 1'($urandom); ari = 1'($urandom); uns = 1'($urandom);
            av = $urandom; bv = $urandom; sh = 5'($urandom);
            if (i % 7 == 0) bv = av;
            model(c, src, dir, ari, uns, av, bv, sh, er, eo, exp_lat);
            do_op(c, src, dir, ari, uns, av, bv, sh, lat, ba);
            checks++;
            if (result !== er || overflow !== eo || zero !== (er == 32'd0) || lat !== exp_lat) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h: got res=%h ovf=%b zero=%b lat=%0d want res=%h ovf=%b zero=%b lat=%0d",
                         c, av, bv, result, overflow, zero, lat, er, eo, (er == 32'd0), exp_lat);
            end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_compare();
        test_var_shift();
        test_zero_shift_lui();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
